// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// Sequencing controller for a serial shift-register stage. Generates SPI mode-0
// SCK and an active-low chip select, registers MISO for the shift register's
// rx input, and drives the shift register's set/en/tick strobes. Reports busy
// and a one-cycle done pulse to the host logic.
//
// Sequence: IDLE -> LOAD -> LEAD -> (HIGH <-> LOW) x WIDTH -> TRAIL -> DONE.
// LEAD, HIGH, LOW and TRAIL each last DIV cycles; LOAD and DONE one cycle.
//
// Optional feature (macro SPI_CTRL_CS_HOLD_EN):
//   Adds the hold input. hold=1 in the last TRAIL cycle keeps ss_n low through
//   DONE into IDLE_HELD; trig there starts a transfer that skips LEAD, and
//   hold=0 there releases ss_n on the next cycle.
//
// Parameters:
//   WIDTH  bits per transfer (2..32), must match the shift-register width
//   DIV    CLKB cycles per SCK half-period (>= 2)
//
// Ports:
//   CLKB        system clock, rising edge
//   RSTN        asynchronous active-low reset
//   trig        start request
//   hold        keep chip select asserted after the transfer (optional)
//   miso        serial data from the slave
//   busy        transfer in progress (LOAD..TRAIL)
//   done        one-cycle pulse at transfer end
//   ss_n        chip select, active low
//   sck         SPI clock, idle low
//   shreg_set   load shift register from its parallel input
//   shreg_en    shift enable
//   shreg_tick  shift strobe, first LOW cycle of each bit
//   shreg_rx    registered MISO bit for the shift register
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic CLKB,
  input  logic RSTN,
  input  logic trig,
`ifdef SPI_CTRL_CS_HOLD_EN
  input  logic hold,
`endif
  input  logic miso,
  output logic busy,
  output logic done,
  output logic ss_n,
  output logic sck,
  output logic shreg_set,
  output logic shreg_en,
  output logic shreg_tick,
  output logic shreg_rx
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned DivW = $clog2(DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLead,
    StHigh,
    StLow,
    StTrail,
    StDone
`ifdef SPI_CTRL_CS_HOLD_EN
    ,
    StIdleHeld
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rx_q, rx_d;
  logic            held_q, held_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ss_n_q, ss_n_d;
  logic            sck_q, sck_d;
  logic            set_q, set_d;
  logic            en_q, en_d;
  logic            tick_q, tick_d;
  logic            div_last;
  logic            timed;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
`ifdef SPI_CTRL_CS_HOLD_EN
    held_d   = held_q;
`else
    held_d   = 1'b0;
`endif
    div_last = (div_q == DivLast);

    unique case (state_q)
      StIdle: begin
        if (trig) state_d = StLoad;
      end
      StLoad: begin
        div_d = '0;
        cnt_d = '0;
`ifdef SPI_CTRL_CS_HOLD_EN
        // Chip select is already asserted, so no setup phase is needed.
        state_d = held_q ? StHigh : StLead;
`else
        state_d = StLead;
`endif
      end
      StLead: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StHigh: begin
        if (div_last) begin
          div_d   = '0;
          rx_d    = miso;
          // Counting on the falling edge means cnt_q == WIDTH after the last bit.
          cnt_d   = cnt_q + CntW'(1);
          state_d = StLow;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StLow: begin
        if (div_last) begin
          div_d   = '0;
          state_d = (cnt_q == CntLast) ? StTrail : StHigh;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StTrail: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StDone;
`ifdef SPI_CTRL_CS_HOLD_EN
          held_d  = hold;
`endif
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
`ifdef SPI_CTRL_CS_HOLD_EN
        if (trig)        state_d = StLoad;
        else if (held_q) state_d = StIdleHeld;
        else             state_d = StIdle;
`else
        state_d = trig ? StLoad : StIdle;
`endif
      end
`ifdef SPI_CTRL_CS_HOLD_EN
      StIdleHeld: begin
        if (trig) begin
          state_d = StLoad;
        end else if (!hold) begin
          state_d = StIdle;
          held_d  = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    timed  = (state_d == StLead) || (state_d == StHigh) ||
             (state_d == StLow)  || (state_d == StTrail);
    busy_d = (state_d == StLoad) || timed;
    done_d = (state_d == StDone);
    ss_n_d = ~(timed || held_d);
    sck_d  = (state_d == StHigh);
    set_d  = (state_d == StLoad);
    en_d   = (state_d == StHigh) || (state_d == StLow);
    tick_d = (state_d == StLow) && (state_q == StHigh);
  end

  always_ff @(posedge CLKB or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      rx_q    <= 1'b0;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      set_q   <= 1'b0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ss_n_q  <= ss_n_d;
      sck_q   <= sck_d;
      set_q   <= set_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ss_n       = ss_n_q;
  assign sck        = sck_q;
  assign shreg_set  = set_q;
  assign shreg_en   = en_q;
  assign shreg_tick = tick_q;
  assign shreg_rx   = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl. The expected outputs come from the offset of
// the current cycle within a transfer (t = 0 is LOAD), computed arithmetically.
// A shift register and SPI slave are modelled around the DUT to check data.
module tb_spi_master_ctrl;

  localparam int WI = 8;
  localparam int DI = 4;
  localparam int T  = 2 + 2 * DI + 2 * DI * WI;  // cycles from LOAD through DONE

  logic CLKB = 1'b0;
  logic RSTN = 1'b0;
  logic trig = 1'b0;
  logic miso;
  logic busy, done, ss_n, sck, shreg_set, shreg_en, shreg_tick, shreg_rx;
`ifdef SPI_CTRL_CS_HOLD_EN
  logic hold_r = 1'b0;
`endif

  always #5 CLKB = ~CLKB;

  spi_master_ctrl #(
    .WIDTH (WI),
    .DIV   (DI)
  ) dut (
    .CLKB       (CLKB),
    .RSTN       (RSTN),
    .trig       (trig),
`ifdef SPI_CTRL_CS_HOLD_EN
    .hold       (hold_r),
`endif
    .miso       (miso),
    .busy       (busy),
    .done       (done),
    .ss_n       (ss_n),
    .sck        (sck),
    .shreg_set  (shreg_set),
    .shreg_en   (shreg_en),
    .shreg_tick (shreg_tick),
    .shreg_rx   (shreg_rx)
  );

  // Edge counter: after edge n, cyc == n; that interval is cycle n+1.
  int cyc = 0;
  always @(posedge CLKB) cyc <= cyc + 1;

  // Downstream shift register and an SPI mode-0 slave.
  logic [WI-1:0] sr = '0;
  logic [WI-1:0] data_in = 8'hA5;
  logic [WI-1:0] slv_word = 8'h3C;
  logic [WI-1:0] slv_tx = '0;
  logic [WI-1:0] slv_rx = '0;
  logic [WI-1:0] cur_din = '0;
  logic [WI-1:0] cur_sw = '0;
  logic          sck_prev_p = 1'b0;
  assign miso = slv_tx[WI-1];

  always @(posedge CLKB) begin
    sck_prev_p <= sck;
    if (shreg_set) begin
      sr       <= data_in;
      slv_tx   <= slv_word;
      cur_din  <= data_in;
      cur_sw   <= slv_word;
      data_in  <= WI'($urandom);
      slv_word <= WI'($urandom);
    end else begin
      if (shreg_tick)          sr     <= {sr[WI-2:0], shreg_rx};
      if (sck && !sck_prev_p)  slv_rx <= {slv_rx[WI-2:0], sr[WI-1]};
      if (!sck && sck_prev_p)  slv_tx <= {slv_tx[WI-2:0], 1'b0};
    end
  end

  // Reference model: t_m is the offset into the running transfer, -1 when idle.
  int   t_m = -1;
  logic exp_rx = 1'b0;
  always @(posedge CLKB or negedge RSTN) begin
    if (!RSTN) begin
      t_m    <= -1;
      exp_rx <= 1'b0;
    end else begin
      if (t_m > DI && t_m < T - 1 - DI && (t_m - 1 - DI) % (2 * DI) == DI - 1) exp_rx <= miso;
      if (t_m >= 0 && t_m < T - 1) t_m <= t_m + 1;
      else                         t_m <= trig ? 0 : -1;
    end
  end

  // {busy, done, ss_n, sck, shreg_set, shreg_en, shreg_tick} at offset t.
  function automatic logic [6:0] exp_outs(int t);
    int p, w;
    if (t < 0)   return 7'b0010000;
    if (t == 0)  return 7'b1010100;
    if (t <= DI) return 7'b1000000;
    p = t - 1 - DI;
    if (p < 2 * DI * WI) begin
      w = p % (2 * DI);
      if (w < DI) return 7'b1001010;
      return (w == DI) ? 7'b1000011 : 7'b1000010;
    end
    if (t < T - 1) return 7'b1000000;
    return 7'b0110000;
  endfunction

  // Activity counters sampled on the falling edge.
  int   n_busy = 0, n_ssl = 0, n_sck = 0, n_tick = 0, n_done = 0;
  logic sck_prev_m = 1'b0;
  always @(negedge CLKB) begin
    if (busy)              n_busy <= n_busy + 1;
    if (!ss_n)             n_ssl  <= n_ssl + 1;
    if (sck && !sck_prev_m) n_sck <= n_sck + 1;
    if (shreg_tick)        n_tick <= n_tick + 1;
    if (done)              n_done <= n_done + 1;
    sck_prev_m <= sck;
  end

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b1;
  int   sb, ss, sk, st, sd;

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKB);
    #1;
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) step();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check1("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic snap();
    sb = n_busy; ss = n_ssl; sk = n_sck; st = n_tick; sd = n_done;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, n;
    fork
      forever begin
        @(negedge CLKB);
        if (RSTN && chk_en) begin
          check1("outputs", {25'b0, busy, done, ss_n, sck, shreg_set, shreg_en, shreg_tick},
                 {25'b0, exp_outs(t_m)});
          check1("shreg_rx", {31'b0, shreg_rx}, {31'b0, exp_rx});
          if (t_m == T - 1) begin
            check1("rx_word", {24'b0, sr}, {24'b0, cur_sw});
            check1("tx_word", {24'b0, slv_rx}, {24'b0, cur_din});
          end
        end
      end
    join_none

    // Reset state
    step();
    step();
    check1("reset_outs", {25'b0, busy, done, ss_n, sck, shreg_set, shreg_en, shreg_tick},
           32'h10);
    check1("reset_rx", {31'b0, shreg_rx}, 32'd0);
    step();
    #1 RSTN = 1'b1;

    // Timing: trig in cycle 10, data 0xA5 out, 0x3C in.
    wait_cyc(9);
    trig = 1'b1;
    step();
    trig = 1'b0;
    snap();
    check1("load_cycle", 32'(cyc + 1), 32'd11);
    check1("load_set", {31'b0, shreg_set}, 32'd1);
    check1("load_ss_n", {31'b0, ss_n}, 32'd1);
    step();
    check1("lead_ss_n", {31'b0, ss_n}, 32'd0);
    wait_done();
    check1("done_cycle", 32'(cyc + 1), 32'd84);
    check1("mosi_word", {24'b0, slv_rx}, 32'hA5);
    check1("miso_word", {24'b0, sr}, 32'h3C);
    @(negedge CLKB);
    #1;
    check1("busy_cycles", 32'(n_busy - sb), 32'd73);
    check1("ss_low_cycles", 32'(n_ssl - ss), 32'd72);
    check1("sck_rises", 32'(n_sck - sk), 32'd8);
    check1("ticks", 32'(n_tick - st), 32'd8);
    check1("dones", 32'(n_done - sd), 32'd1);

    // trig pulses in LEAD and in LOW of bit 5 are ignored.
    step();
    trig = 1'b1;
    step();
    k = cyc;
    trig = 1'b0;
    snap();
    wait_cyc(k + 2);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_cyc(k + 49);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_done();
    @(negedge CLKB);
    #1;
    check1("ign_ticks", 32'(n_tick - st), 32'd8);
    check1("ign_dones", 32'(n_done - sd), 32'd1);
    repeat (5) step();
    check1("ign_idle_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset during HIGH of bit 3.
    trig = 1'b1;
    step();
    k = cyc;
    trig = 1'b0;
    wait_cyc(k + 30);
    check1("pre_reset_sck", {31'b0, sck}, 32'd1);
    #2 RSTN = 1'b0;
    #1;
    check1("async_ss_n", {31'b0, ss_n}, 32'd1);
    check1("async_sck", {31'b0, sck}, 32'd0);
    check1("async_busy", {31'b0, busy}, 32'd0);
    step();
    check1("no_done_in_reset", {31'b0, done}, 32'd0);
    step();
    #1 RSTN = 1'b1;
    step();
    check1("no_done_after_reset", {31'b0, done}, 32'd0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    snap();
    wait_done();
    @(negedge CLKB);
    #1;
    check1("post_reset_ticks", 32'(n_tick - st), 32'd8);

    // trig held high: back-to-back words, ss_n high only in DONE and LOAD.
    step();
    snap();
    trig = 1'b1;
    wait_done();
    for (int g = 0; g < 2; g++) begin
      n = 0;
      while (ss_n && n < 10) begin
        n++;
        step();
      end
      check1("b2b_ss_gap", 32'(n), 32'd2);
      wait_done();
    end
    trig = 1'b0;
    @(negedge CLKB);
    #1;
    check1("b2b_dones", 32'(n_done - sd), 32'd3);
    step();

    // Random trig traffic with random data words.
    repeat (1500) begin
      trig = ($urandom_range(0, 7) == 0);
      step();
    end
    trig = 1'b0;
    repeat (T + 5) step();

`ifdef SPI_CTRL_CS_HOLD_EN
    // Chip select held across two words, released one cycle after hold drops.
    chk_en = 1'b0;
    hold_r = 1'b1;
    trig   = 1'b1;
    step();
    trig = 1'b0;
    wait_done();
    check1("held_done_ss_n", {31'b0, ss_n}, 32'd0);
    step();
    step();
    check1("held_idle_ss_n", {31'b0, ss_n}, 32'd0);
    check1("held_idle_busy", {31'b0, busy}, 32'd0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    k = 0;
    while (done !== 1'b1 && n < 300) begin
      if (ss_n) k++;
      step();
      n++;
    end
    check1("held_2nd_done", {31'b0, done}, 32'd1);
    check1("held_ss_high_cycles", 32'(k), 32'd0);
    hold_r = 1'b0;
    step();
    check1("held_release_wait", {31'b0, ss_n}, 32'd0);
    step();
    check1("held_release", {31'b0, ss_n}, 32'd1);
    #1 RSTN = 1'b0;
    step();
    #1 RSTN = 1'b1;
    chk_en = 1'b1;
`endif

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Sequencing controller for the serial shift-register stage. Sits directly upstream of it and drives its set/en/tick/rx inputs.
Generates SPI mode-0 SCK and active-low chip select, and registers MISO for the shift-register rx input.
Reports busy/done to the host logic, which reads the received word from the shift register's parallel output after done.

Parameters:
WIDTH, 8, bits per transfer; must match the shift-register width; 2..32.
DIV, 4, CLKB cycles per SCK half-period; minimum 2.

Ports:
CLKB  input  1  system clock, all state on rising edge
RSTN  input  1  asynchronous active-low reset
trig  input  1  start request, sampled each CLKB edge
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
ss_n  output  1  SPI chip select, active low
sck  output  1  SPI clock, idle low
miso  input  1  SPI data from slave
shreg_set  output  1  load shift register from its parallel input
shreg_en  output  1  shift enable
shreg_tick  output  1  shift strobe
shreg_rx  output  1  registered MISO bit to the shift-register rx input
hold  input  1  present only with SPI_CTRL_CS_HOLD_EN, see below

Behaviour:
- Reset (RSTN low, takes effect immediately, no clock needed):
  - state IDLE; divider, bit counter and shreg_rx cleared to 0.
  - ss_n=1, sck=0; busy, done, shreg_set, shreg_en, shreg_tick all 0.
  - Reset mid-transfer aborts it; no done pulse is issued.
- States and transitions: IDLE -> LOAD -> LEAD -> HIGH <-> LOW -> TRAIL -> DONE -> IDLE.
- Divider: counts 0..DIV-1 in LEAD, HIGH, LOW and TRAIL. The state advances when the count is DIV-1; the count is then cleared.
- IDLE:
  - busy=0, ss_n=1, sck=0.
  - trig=1 -> LOAD.
- LOAD (1 cycle):
  - shreg_set=1, busy=1, ss_n still 1.
- LEAD (DIV cycles):
  - ss_n=0, sck=0. Provides setup time for the MSB already on tx.
- HIGH (DIV cycles):
  - sck=1, shreg_en=1.
  - On the last cycle, miso is captured into shreg_rx.
- LOW (DIV cycles):
  - sck=0, shreg_en=1.
  - shreg_tick=1 on the first LOW cycle only, so the shift occurs one CLKB after the SCK falling edge.
  - The bit counter increments on that cycle.
  - At the end of LOW: if the counter is below WIDTH, go to HIGH; if it equals WIDTH, go to TRAIL.
- TRAIL (DIV cycles):
  - ss_n=0, sck=0, shreg_en=0. Provides hold time after the last falling edge.
- DONE (1 cycle):
  - done=1, busy=0, ss_n=1. Then go to IDLE.
  - trig=1 in DONE is accepted: go directly to LOAD.
- Busy rule: trig during LOAD..TRAIL is ignored, not queued.
- Output timing: every output is registered; no combinational path from any input to any output.
- Timing: trig sampled at edge k -> done high in cycle k+2+2*DIV+2*DIV*WIDTH. For the defaults this is k+74.
- Counter wrap: the bit counter is $clog2(WIDTH+1) bits, cleared in LOAD, and never wraps within a transfer.
- Tick count: exactly WIDTH shreg_tick pulses and WIDTH SCK rising edges per transfer.

Optional Feature:
SPI_CTRL_CS_HOLD_EN:
- Defined: the hold port exists.
  - hold=1 sampled in the last TRAIL cycle -> DONE keeps ss_n=0, and the controller enters IDLE_HELD with ss_n=0.
  - trig in IDLE_HELD goes LOAD -> HIGH, skipping LEAD.
  - hold=0 in IDLE_HELD releases ss_n to 1 on the next cycle and returns to IDLE.
- Undefined: no hold port and no IDLE_HELD state; ss_n is always released in DONE.

Test Plan:
- Reset during HIGH of bit 3 -> ss_n=1, sck=0, busy=0 asynchronously; no done pulse; next trig runs a full transfer.
- WIDTH=8, DIV=4, data_in=0xA5, slave returns 0x3C -> MOSI (shift-register tx) sampled on SCK rising edges reads 0xA5; shift-register data_out=0x3C at done.
- Timing check, trig at cycle 10 -> shreg_set in cycle 11, ss_n falls in cycle 12, 8 SCK pulses each 8 CLKB long, done in cycle 84, busy 73 cycles.
- trig held high continuously -> back-to-back transfers; LOAD immediately follows each DONE; ss_n high for exactly 2 cycles (DONE, LOAD) between words.
- trig pulsed in LEAD and again in LOW of bit 5 -> both ignored; exactly 8 shreg_tick pulses and one done.
- With SPI_CTRL_CS_HOLD_EN, hold=1 for two words then hold=0 -> ss_n low continuously across both words; ss_n high 1 cycle after hold drops in IDLE_HELD.
